// File: rtl/render_pkg.sv
// Shared colours, FSM encoding and address helper for the frame renderer.
package render_pkg;

  localparam int unsigned COLOR_W = 24;

  localparam logic [COLOR_W-1:0] BKCOLOR = 24'hFFFFFF;
  localparam logic [COLOR_W-1:0] BLOCK   = 24'hF0FFF0;
  localparam logic [COLOR_W-1:0] DOODLE  = 24'h08FF08;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_WAIT,
    ST_DRAW_BLK,
    ST_NEXT,
    ST_DRAW_DOODLE,
    ST_DONE
  } render_state_e;

  // Column-major framebuffer address: x selects the column, y the row within it.
  function automatic logic [31:0] pix_addr(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [31:0] height);
    return x * height + y;
  endfunction

endpackage

// File: rtl/rect_walker.sv
// Rectangle rasteriser: walks (org+dx, org+dy), dy inner, dx outer, and issues
// one framebuffer write per on-screen pixel through a valid/ready handshake.
module rect_walker
  import render_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 400,
  parameter int unsigned SCREEN_HEIGHT = 700,
  parameter int unsigned COORD_W       = 16,
  parameter int unsigned ADDR_W        = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go_i,
  input  logic [COORD_W-1:0] org_x_i,
  input  logic [COORD_W-1:0] org_y_i,
  input  logic [COORD_W-1:0] width_i,
  input  logic [COORD_W-1:0] height_i,
  input  logic [COLOR_W-1:0] color_i,
  input  logic               wr_ready_i,
  output logic               wr_valid_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [COLOR_W-1:0] wr_color_o,
  output logic               done_o
);

  localparam int unsigned SUM_W = COORD_W + 1;

  logic [COORD_W-1:0] ox_q, oy_q, w_q, h_q, dx_q, dy_q;
  logic [COLOR_W-1:0] col_q;
  logic               run_q, pend_q, done_q;
  logic               wr_valid_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [COLOR_W-1:0] wr_color_q;

  logic [SUM_W-1:0]   px_c, py_c;
  logic [ADDR_W:0]    addr_c;
  logic               clip_c, out_free_c, last_c, col_end_c;

  // Current pixel position, one bit wider than a coordinate so it never wraps.
  assign px_c = SUM_W'(ox_q) + SUM_W'(dx_q);
  assign py_c = SUM_W'(oy_q) + SUM_W'(dy_q);
  assign addr_c = (ADDR_W+1)'(pix_addr(32'(px_c), 32'(py_c), SCREEN_HEIGHT));
  assign clip_c = (px_c >= SUM_W'(SCREEN_WIDTH)) || (py_c >= SUM_W'(SCREEN_HEIGHT)) ||
                  (addr_c >= (ADDR_W+1)'(SCREEN_WIDTH * SCREEN_HEIGHT));
  assign out_free_c = !wr_valid_q || wr_ready_i;
  assign col_end_c  = (dy_q == h_q - COORD_W'(1));
  assign last_c     = col_end_c && (dx_q == w_q - COORD_W'(1));

  // Pixel walk; the output register only reloads once the pending write is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_q       <= '0;
      oy_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      col_q      <= '0;
      run_q      <= 1'b0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_color_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (go_i) begin
        ox_q   <= org_x_i;
        oy_q   <= org_y_i;
        w_q    <= width_i;
        h_q    <= height_i;
        col_q  <= color_i;
        dx_q   <= '0;
        dy_q   <= '0;
        run_q  <= 1'b1;
        pend_q <= 1'b1;
      end else if (pend_q && out_free_c) begin
        if (run_q) begin
          // Clipped pixels spend one cycle with no write and still advance.
          wr_valid_q <= !clip_c;
          if (!clip_c) begin
            wr_addr_q  <= ADDR_W'(addr_c);
            wr_color_q <= col_q;
          end
          if (last_c) begin
            run_q <= 1'b0;
          end else if (col_end_c) begin
            dy_q <= '0;
            dx_q <= dx_q + COORD_W'(1);
          end else begin
            dy_q <= dy_q + COORD_W'(1);
          end
        end else begin
          wr_valid_q <= 1'b0;
          pend_q     <= 1'b0;
          done_q     <= 1'b1;
        end
      end
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_color_o = wr_color_q;
  assign done_o     = done_q;

endmodule

// File: rtl/frame_render_ctrl.sv
// Frame sequencer: clear, paint active platforms from the block table, then the doodle.
module frame_render_ctrl
  import render_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 400,
  parameter int unsigned SCREEN_HEIGHT = 700,
  parameter int unsigned BLOCK_WIDTH   = 40,
  parameter int unsigned BLOCK_HEIGHT  = 5,
  parameter int unsigned DOODLE_SIZE   = 8,
  parameter int unsigned MAX_BLOCKS    = 16,
  parameter int unsigned COORD_W       = 16,
  parameter int unsigned ADDR_W        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  parameter int unsigned IDX_W         = $clog2(MAX_BLOCKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [COORD_W-1:0] doodle_x_i,
  input  logic [COORD_W-1:0] doodle_y_i,
  output logic [IDX_W-1:0]   blk_idx_o,
  input  logic [COORD_W-1:0] blk_x_i,
  input  logic [COORD_W-1:0] blk_y_i,
  input  logic               blk_active_i,
  output logic               wr_valid_o,
  input  logic               wr_ready_i,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [COLOR_W-1:0] wr_color_o,
  output logic               busy_o,
  output logic               frame_done_o
);

  render_state_e      state_q;
  logic               busy_q, frame_done_q, go_q;
  logic [IDX_W-1:0]   blk_idx_q;
  logic [COORD_W-1:0] snap_x_q, snap_y_q;
  logic [COORD_W-1:0] org_x_q, org_y_q, size_w_q, size_h_q;
  logic [COLOR_W-1:0] color_q;
  logic               walk_done;

  // Frame FSM; each drawing phase loads the walker's rectangle and pulses go_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      go_q         <= 1'b0;
      blk_idx_q    <= '0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
      org_x_q      <= '0;
      org_y_q      <= '0;
      size_w_q     <= '0;
      size_h_q     <= '0;
      color_q      <= '0;
    end else begin
      go_q         <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (start_i) begin
          snap_x_q <= doodle_x_i;
          snap_y_q <= doodle_y_i;
          busy_q   <= 1'b1;
          org_x_q  <= '0;
          org_y_q  <= '0;
          size_w_q <= COORD_W'(SCREEN_WIDTH);
          size_h_q <= COORD_W'(SCREEN_HEIGHT);
          color_q  <= BKCOLOR;
          go_q     <= 1'b1;
          state_q  <= ST_CLEAR;
        end
        ST_CLEAR: if (walk_done) begin
          blk_idx_q <= '0;
          state_q   <= ST_FETCH;
        end
        ST_FETCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (blk_active_i) begin
            org_x_q  <= blk_x_i;
            org_y_q  <= blk_y_i;
            size_w_q <= COORD_W'(BLOCK_WIDTH);
            size_h_q <= COORD_W'(BLOCK_HEIGHT);
            color_q  <= BLOCK;
            go_q     <= 1'b1;
            state_q  <= ST_DRAW_BLK;
          end else begin
            state_q <= ST_NEXT;
          end
        end
        ST_DRAW_BLK: if (walk_done) state_q <= ST_NEXT;
        ST_NEXT: begin
          if (blk_idx_q == IDX_W'(MAX_BLOCKS - 1)) begin
            org_x_q  <= snap_x_q;
            org_y_q  <= snap_y_q;
            size_w_q <= COORD_W'(DOODLE_SIZE);
            size_h_q <= COORD_W'(DOODLE_SIZE);
            color_q  <= DOODLE;
            go_q     <= 1'b1;
            state_q  <= ST_DRAW_DOODLE;
          end else begin
            blk_idx_q <= blk_idx_q + IDX_W'(1);
            state_q   <= ST_FETCH;
          end
        end
        ST_DRAW_DOODLE: if (walk_done) begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rect_walker #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .COORD_W      (COORD_W),
    .ADDR_W       (ADDR_W)
  ) u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .go_i      (go_q),
    .org_x_i   (org_x_q),
    .org_y_i   (org_y_q),
    .width_i   (size_w_q),
    .height_i  (size_h_q),
    .color_i   (color_q),
    .wr_ready_i(wr_ready_i),
    .wr_valid_o(wr_valid_o),
    .wr_addr_o (wr_addr_o),
    .wr_color_o(wr_color_o),
    .done_o    (walk_done)
  );

  assign blk_idx_o    = blk_idx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_frame_render_ctrl.sv
// Bench for frame_render_ctrl on an 8x6 screen with a loop-based frame model.
module tb_frame_render_ctrl;

  localparam int unsigned SW = 8, SH = 6, BW = 3, BH = 2, DS = 2, NB = 4, CW = 16;
  localparam int unsigned AW = $clog2(SW * SH);
  localparam int unsigned IW = $clog2(NB);
  localparam logic [23:0] C_BG = 24'hFFFFFF, C_BLK = 24'hF0FFF0, C_DOO = 24'h08FF08;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [23:0]   c;
  } wr_t;

  typedef struct packed {
    logic [NB-1:0][CW-1:0] bx;
    logic [NB-1:0][CW-1:0] by;
    logic [NB-1:0]         ba;
    logic [CW-1:0]         dx;
    logic [CW-1:0]         dy;
    logic                  rnd;
    logic [7:0]            exp_writes;
  } vec_t;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_ready = 1'b1;
  logic [CW-1:0] doodle_x = '0, doodle_y = '0;
  logic [IW-1:0] blk_idx;
  logic [CW-1:0] blk_x = '0, blk_y = '0;
  logic          blk_active = 1'b0;
  logic          wr_valid, busy, frame_done;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_color;

  logic [CW-1:0] tb_bx[NB];
  logic [CW-1:0] tb_by[NB];
  logic          tb_ba[NB];
  logic          rnd_ready = 1'b0;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  int   idx_log[$];
  int   checks = 0, bad = 0;
  int   cyc = 0, last_acc_cyc = 0, bg_end_cyc = 32'h3FFF_FFFF, last_idx = -1;
  logic stall_prev = 1'b0;
  wr_t  stall_w;
  vec_t vecs[6];

  frame_render_ctrl #(
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH),
    .DOODLE_SIZE(DS), .MAX_BLOCKS(NB), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .doodle_x_i(doodle_x), .doodle_y_i(doodle_y),
    .blk_idx_o(blk_idx), .blk_x_i(blk_x), .blk_y_i(blk_y), .blk_active_i(blk_active),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_color_o(wr_color),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  // Block table memory with one cycle of read latency.
  always @(posedge clk) begin
    blk_x      <= tb_bx[blk_idx];
    blk_y      <= tb_by[blk_idx];
    blk_active <= tb_ba[blk_idx];
  end

  // Framebuffer back-pressure.
  initial forever begin
    @(posedge clk); #1;
    wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Write monitor, stall-hold check and block index log.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (stall_prev) begin
        checks = checks + 1;
        if (!wr_valid || wr_addr != stall_w.a || wr_color != stall_w.c) begin
          bad = bad + 1;
          $display("FAIL stall_hold: got v=%0b a=%0d c=%h expected v=1 a=%0d c=%h",
                   wr_valid, wr_addr, wr_color, stall_w.a, stall_w.c);
        end
      end
      stall_prev = wr_valid && !wr_ready;
      stall_w    = {wr_addr, wr_color};
      if (wr_valid && wr_ready) begin
        got_q.push_back({wr_addr, wr_color});
        last_acc_cyc = cyc;
        if (got_q.size() == SW * SH) bg_end_cyc = cyc;
      end
      if (busy && cyc > bg_end_cyc + 1 && int'(blk_idx) != last_idx) begin
        idx_log.push_back(int'(blk_idx));
        last_idx = int'(blk_idx);
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic paint(input int ox, input int oy, input int w, input int h, input logic [23:0] c);
    for (int i = 0; i < w; i++)
      for (int j = 0; j < h; j++)
        if (ox + i < int'(SW) && oy + j < int'(SH))
          exp_q.push_back({AW'((ox + i) * int'(SH) + oy + j), c});
  endtask

  // Expected write stream: background, each active block in table order, then the doodle.
  task automatic build_model(input vec_t v);
    exp_q.delete();
    paint(0, 0, SW, SH, C_BG);
    for (int b = 0; b < NB; b++)
      if (v.ba[b]) paint(int'(v.bx[b]), int'(v.by[b]), BW, BH, C_BLK);
    paint(int'(v.dx), int'(v.dy), DS, DS, C_DOO);
  endtask

  task automatic load_vec(input vec_t v);
    for (int b = 0; b < NB; b++) begin
      tb_bx[b] = v.bx[b];
      tb_by[b] = v.by[b];
      tb_ba[b] = v.ba[b];
    end
    doodle_x  = v.dx;
    doodle_y  = v.dy;
    rnd_ready = v.rnd;
  endtask

  task automatic begin_frame();
    @(posedge clk); #1;
    got_q.delete();
    idx_log.delete();
    last_idx   = -1;
    bg_end_cyc = 32'h3FFF_FFFF;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit disturb, input string name);
    bit seen = 1'b0;
    bit lv;
    int fd_cyc = 0;
    load_vec(v);
    build_model(v);
    lv = (int'(v.dx) + int'(DS) - 1 < int'(SW)) && (int'(v.dy) + int'(DS) - 1 < int'(SH));
    begin_frame();
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk); #1;
      if (disturb && k == 20) begin
        doodle_x = doodle_x + 16'd3;
        doodle_y = doodle_y + 16'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (frame_done) begin
        seen   = 1'b1;
        fd_cyc = cyc;
      end
    end
    start = 1'b0;
    checks = checks + 1;
    if (!seen) begin
      bad = bad + 1;
      $display("FAIL %s frame_timeout: got no frame_done expected pulse within 3000 cycles", name);
    end else begin
      chk({name, " busy_at_done"}, 64'(busy), 64'd0);
      if (lv) chk({name, " done_latency"}, 64'(fd_cyc - last_acc_cyc), 64'd2);
    end
    @(negedge clk); #1;
    chk({name, " done_pulse_width"}, 64'(frame_done), 64'd0);
    repeat (5) @(negedge clk);
    #1;
    chk({name, " idle_busy"}, 64'(busy), 64'd0);
    chk({name, " write_count"}, 64'(got_q.size()), 64'(v.exp_writes));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s wr[%0d] addr_color", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({name, " blk_idx_seq"},
        64'(idx_log.size() == 4 && idx_log[0] == 0 && idx_log[1] == 1 &&
            idx_log[2] == 2 && idx_log[3] == 3), 64'd1);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      tb_bx[b] = '0; tb_by[b] = '0; tb_ba[b] = 1'b0;
    end
    for (int v = 0; v < 6; v++) vecs[v] = '0;
    // All inactive, doodle at origin.
    vecs[0].exp_writes = 8'd52;
    // Block 2 at (1,1).
    vecs[1].bx[2] = 16'd1; vecs[1].by[2] = 16'd1; vecs[1].ba[2] = 1'b1;
    vecs[1].dx = 16'd4; vecs[1].dy = 16'd2; vecs[1].exp_writes = 8'd58;
    // Block hanging off the bottom-right corner.
    vecs[2].bx[0] = 16'd6; vecs[2].by[0] = 16'd5; vecs[2].ba[0] = 1'b1;
    vecs[2].dx = 16'd3; vecs[2].dy = 16'd2; vecs[2].exp_writes = 8'd54;
    // Same as vector 1 under random back-pressure.
    vecs[3] = vecs[1]; vecs[3].rnd = 1'b1;
    // Every block active, including one at the coordinate limit and a partly clipped doodle.
    vecs[4].bx = {16'hFFFF, 16'd7, 16'd5, 16'd0};
    vecs[4].by = {16'hFFFF, 16'd0, 16'd4, 16'd0};
    vecs[4].ba = 4'b1111;
    vecs[4].dx = 16'd7; vecs[4].dy = 16'd5; vecs[4].rnd = 1'b1; vecs[4].exp_writes = 8'd63;
    // Doodle entirely off-screen.
    vecs[5].dx = 16'hFFFF; vecs[5].exp_writes = 8'd48;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst wr_valid", 64'(wr_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst frame_done", 64'(frame_done), 64'd0);
    chk("rst blk_idx", 64'(blk_idx), 64'd0);
    chk("rst wr_addr", 64'(wr_addr), 64'd0);
    chk("rst wr_color", 64'(wr_color), 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_frame(vecs[v], 1'b0, $sformatf("vec%0d", v));

    // Doodle moves and start pulses while busy: snapshot holds, no extra frame.
    run_frame(vecs[2], 1'b1, "snapshot");

    // Reset while a platform is being drawn.
    load_vec(vecs[1]);
    begin_frame();
    for (int k = 0; k < 500 && got_q.size() <= SW * SH + 1; k++) @(negedge clk);
    chk("abort reached_draw_blk", 64'(got_q.size() > SW * SH + 1), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort wr_valid", 64'(wr_valid), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort held wr_valid", 64'(wr_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(vecs[1], 1'b0, "after_abort");

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
